nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a multi-nibble add/subtract by time-multiplexing one 4-bit full-adder slice.
- Processes one nibble per cycle, LSB first, and chains the carry through a register.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out).
- Trades latency for area in arithmetic paths wider than 4 bits.

Parameters:
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES (default 16 bits); legal range >= 1.

Ports:
- clk        input   1  rising-edge clock.
- rst_n      input   1  asynchronous active-low reset.
- in_valid   input   1  requester has an operation on a/b/cin/sub.
- in_ready   output  1  block can accept an operation.
- a          input   W  operand A (unsigned or two's complement).
- b          input   W  operand B.
- cin        input   1  carry-in for add; ignored when sub=1.
- sub        input   1  1 = A - B, 0 = A + B + cin.
- out_valid  output  1  result on sum/cout/ovf is valid.
- out_ready  input   1  consumer accepts the result.
- sum        output  W  result.
- cout       output  1  carry out of the MSB (add: carry; sub: 1 = no borrow).
- ovf        output  1  signed overflow.

Behaviour:
- Reset: asynchronous, active-low, async assert; FSM goes to IDLE; nibble index = 0.
  - Output reset values: out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
  - Internal registers (A, B, carry) cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at a clock edge: latch a into A.
  - Latch B as b when sub=0, or ~b when sub=1.
  - Latch carry as cin when sub=0, or 1 when sub=1.
  - Clear the index; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: {c4, s} = A[4i+3:4i] + B[4i+3:4i] + carry, with i = current index.
  - sum[4i+3:4i] <= s; carry <= c4.
  - At i = NIBBLES-1, also register:
    - ovf = carry into MSB bit XOR carry out of MSB bit;
    - cout = c4.
  - Then go to DONE. Otherwise index++.
  - Exactly NIBBLES cycles in RUN; NIBBLES=1 gives one RUN cycle.
- DONE:
  - out_valid=1; sum/cout/ovf held stable.
  - On out_ready=1 at an edge: go to IDLE (in_ready=1 on the next cycle).
  - out_valid stays high indefinitely while out_ready=0.
- Latency: the accept edge is cycle 0; out_valid is high from cycle NIBBLES onward.
- Throughput: at most one operation per NIBBLES+2 cycles (no overlap of accept with DONE).
- sum is updated nibble-wise during RUN. Consumers must sample only when out_valid=1. Upper nibbles hold the previous result until overwritten.
- in_valid/a/b/cin/sub are ignored outside IDLE; changes to them during RUN or DONE do not affect the result.
- out_ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE: the operation is discarded, outputs take reset values, and no out_valid pulse is produced.
- All arithmetic is modulo 2^W; the carry chain never extends beyond nibble NIBBLES-1.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FF0, cin=0 -> out_valid at cycle 4 after accept; sum=0x2224, cout=0, ovf=0; in_ready low for cycles 1..4.
- Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 - 0x0007 (cin=1, ignored) -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready low for 3 cycles in DONE while a/b/in_valid toggle -> sum/cout/ovf stable, in_ready=0; on out_ready=1 return to IDLE, and the next accepted op (0x0001 + 0x0001) gives 0x0002.
- Assert rst_n=0 at RUN index 2 of 0xAAAA + 0x5555 -> immediately out_valid=0, in_ready=1, sum=0. After release, 0x0003 + 0x0004 gives 0x0007 with normal latency.
- NIBBLES=1 instance: 0xF + 0x1, cin=0 -> sum=0x0, cout=1, ovf=0, out_valid one cycle after accept.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: W-bit add/subtract built from a single 4-bit adder
// slice. The slice is reused over NIBBLES cycles, LSB nibble first, and the
// carry between nibbles lives in a register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation (in_ready=1)
// RUN   | adding one nibble per cycle, idx_q selects the active nibble
// DONE  | result held on sum/cout/ovf with out_valid=1 until out_ready
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] low3;
  logic [4:0] total;
  logic       c3;
  logic       c4;

  // Select the active nibble of A and B; constant part-selects keep the mux explicit.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // The shared 4-bit slice; c3 is the carry into the nibble's top bit, used for ovf.
  always_comb begin
    low3  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
    total = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    c3    = low3[3];
    c4    = total[4];
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so B is inverted and the carry forced to 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[4*i +: 4] = total[3:0];
          end
        end
        carry_d = c4;
        if (idx_q == LAST_IDX) begin
          ovf_d   = c3 ^ c4;
          cout_d  = c4;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: a 16-bit (NIBBLES=4) instance
// and a 4-bit (NIBBLES=1) instance, checked against an arithmetic model.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0]  s_a, s_b, s_sum;
  logic        s_cin, s_sub, s_cout, s_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  s_exp_q[$];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic, result {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input longint ma, input longint mb,
                                        input logic mcin, input logic msub);
    longint mask, bb, full, s;
    logic co, ov;
    mask = (longint'(1) << w) - 1;
    ma   = ma & mask;
    bb   = msub ? (~mb & mask) : (mb & mask);
    full = ma + bb + (msub ? 1 : longint'(mcin));
    s    = full & mask;
    co   = ((full >> w) & 1) != 0;
    ov   = (((ma >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
           (((s >> (w-1)) & 1) != ((ma >> (w-1)) & 1));
    return {ov, co, s[31:0]};
  endfunction

  // Monitor for the 16-bit instance: compare each result as it is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(e[15:0]));
        chk("cout", 64'(cout), 64'(e[16]));
        chk("ovf", 64'(ovf), 64'(e[17]));
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        chk("n1_unexpected_result", 64'd1, 64'd0);
      end else begin
        logic [5:0] e;
        e = s_exp_q.pop_front();
        chk("n1_sum", 64'(s_sum), 64'(e[3:0]));
        chk("n1_cout", 64'(s_cout), 64'(e[4]));
        chk("n1_ovf", 64'(s_ovf), 64'(e[5]));
      end
    end
  end

  // Present an operation and wait for it to be accepted; returns just after the accept edge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb2, input logic tcin,
                       input logic tsub);
    logic [33:0] m;
    int n;
    a = ta; b = tb2; cin = tcin; sub = tsub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
    m = model(16, longint'(ta), longint'(tb2), tcin, tsub);
    exp_q.push_back({m[33], m[32], m[15:0]});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full operation: accept, check RUN/latency, hold DONE for 'hold' cycles, then hand over.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tcin,
                       input logic tsub, input int hold);
    logic [33:0] m;
    int n;
    m = model(16, longint'(ta), longint'(tb2), tcin, tsub);
    out_ready = 1'b0;
    issue(ta, tb2, tcin, tsub);
    n = 0;
    while (!out_valid && n < 20) begin
      chk("in_ready_run", 64'(in_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'd4);
    for (int h = 0; h < hold; h++) begin
      chk("hold_sum", 64'(sum), 64'(m[15:0]));
      chk("hold_cout_ovf", 64'({ovf, cout}), 64'({m[33], m[32]}));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      cin = 1'($urandom); in_valid = ~in_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  // One operation on the NIBBLES=1 instance: result expected one cycle after accept.
  task automatic small_op(input logic [3:0] ta, input logic [3:0] tb2, input logic tcin,
                          input logic tsub);
    logic [33:0] m;
    m = model(4, longint'(ta), longint'(tb2), tcin, tsub);
    s_a = ta; s_b = tb2; s_cin = tcin; s_sub = tsub; s_in_valid = 1'b1;
    chk("n1_in_ready", 64'(s_in_ready), 64'd1);
    s_exp_q.push_back({m[33], m[32], m[3:0]});
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("n1_not_yet_valid", 64'(s_out_valid), 64'd0);
    @(posedge clk); #1;
    chk("n1_latency_valid", 64'(s_out_valid), 64'd1);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0FF0, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 3);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    // Reset during RUN, after two nibbles have been written.
    out_ready = 1'b0;
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_partial_sum", 64'(sum), 64'h00FF);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_rst_sum", 64'(sum), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_valid", 64'(out_valid), 64'd0);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    small_op(4'hF, 4'h1, 1'b0, 1'b0);
    small_op(4'h7, 4'h0, 1'b1, 1'b0);
    small_op(4'h8, 4'h1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      small_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size() + s_exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
